// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stream capture/transmit path.
// Beat layout: [31:0] real, [63:32] imaginary.
package fft_pkg;

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

    localparam logic WORD_RE = 1'b0;
    localparam logic WORD_IM = 1'b1;

    function automatic logic [63:0] pack_beat(
        input logic [31:0] re,
        input logic [31:0] im
    );
        return {im, re};
    endfunction

    function automatic logic [31:0] beat_word(
        input logic [63:0] beat,
        input logic        sel
    );
        logic [31:0] w;
        w = beat[31:0];
        unique case (sel)
            WORD_RE: w = beat[31:0];
            WORD_IM: w = beat[63:32];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fft_capture_ram.sv
// NFFT x 64 frame buffer: one 64-bit write port, async 32-bit read port.
// Contents are intentionally not reset.
module fft_capture_ram
    import fft_pkg::*;
#(
    parameter  int NFFT   = 8,
    localparam int ADDR_W = $clog2(NFFT * 2),
    localparam int CNT_W  = $clog2(NFFT)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [CNT_W-1:0]  waddr,
    input  logic [63:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [63:0] mem [NFFT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle read of a beat being written returns the old contents.
    assign rdata = beat_word(mem[raddr[ADDR_W-1:1]], raddr[0]);

endmodule

// File: rtl/fft_stream_capture.sv
// AXI-Stream slave capturing one NFFT-point complex frame for
// register-mapped readback, with completion pulse and tlast checking.
module fft_stream_capture
    import fft_pkg::*;
#(
    parameter  int NFFT   = 8,
    localparam int ADDR_W = $clog2(NFFT * 2),
    localparam int CNT_W  = $clog2(NFFT)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [63:0]       s_axis_tdata,
    input  logic [ADDR_W-1:0] rAddr,
    output logic [31:0]       rData,
    input  logic              rearm,
    output logic              received,
    output logic              tlast_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NFFT - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             err_n;
    logic             recv_n;
    logic             accept;
    logic             we;
    logic             last_beat;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign last_beat = (count == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_CAPTURE;
            count         <= '0;
            s_axis_tready <= 1'b0;
            received      <= 1'b0;
            tlast_err     <= 1'b0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            s_axis_tready <= (state_n == ST_CAPTURE);
            received      <= recv_n;
            tlast_err     <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        err_n   = tlast_err;
        recv_n  = 1'b0;
        we      = 1'b0;
        if (rearm) begin
            // Rearm wins: a coincident beat is consumed but dropped.
            state_n = ST_CAPTURE;
            count_n = '0;
            err_n   = 1'b0;
        end else begin
            unique case (state)
                ST_CAPTURE: begin
                    if (accept) begin
                        we = 1'b1;
                        if (last_beat) begin
                            state_n = ST_DONE;
                            count_n = '0;
                            recv_n  = 1'b1;
                            if (!s_axis_tlast) begin
                                err_n = 1'b1;
                            end
                        end else if (s_axis_tlast) begin
                            // Early tlast: resync to the next frame.
                            err_n   = 1'b1;
                            count_n = '0;
                        end else begin
                            count_n = count + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
            endcase
        end
    end

    fft_capture_ram #(
        .NFFT (NFFT)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (count),
        .wdata (s_axis_tdata),
        .raddr (rAddr),
        .rdata (rData)
    );

endmodule

// File: tb/tb_fft_stream_capture.sv
// Directed bench for fft_stream_capture with a readback scoreboard.
module tb_fft_stream_capture;
    import fft_pkg::*;

    localparam int NFFT   = 8;
    localparam int ADDR_W = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } rd_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              tvalid = 1'b0;
    logic              tready;
    logic              tlast = 1'b0;
    logic [63:0]       tdata = '0;
    logic [ADDR_W-1:0] raddr = '0;
    logic [31:0]       rdata;
    logic              rearm = 1'b0;
    logic              received;
    logic              tlast_err;

    int  n_cmp = 0;
    int  n_err = 0;
    int  recv_cnt = 0;
    int  r0;
    rd_t sb[$];

    fft_stream_capture #(
        .NFFT (NFFT)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .s_axis_tdata  (tdata),
        .rAddr         (raddr),
        .rData         (rdata),
        .rearm         (rearm),
        .received      (received),
        .tlast_err     (tlast_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (received === 1'b1) recv_cnt <= recv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] beat(input int base, input int k);
        return pack_beat(32'(base + k), 32'(base + k + 'h100));
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic last,
                             input bit store, input int k);
        int waited;
        waited = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        while (tready !== 1'b1 && waited < 32) begin
            tick();
            waited++;
        end
        if (waited >= 32) check("tready_timeout", {31'b0, tready}, 1);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (store) begin
            sb.push_back('{ADDR_W'(2 * k), d[31:0]});
            sb.push_back('{ADDR_W'(2 * k + 1), d[63:32]});
        end
    endtask

    task automatic send_frame(input int base, input int n, input int last_at,
                              input bit gaps, input bit store);
        for (int k = 0; k < n; k++) begin
            if (gaps) tick($urandom_range(0, 3));
            send_beat(beat(base, k), k == last_at, store, k);
        end
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a,
                             output logic [31:0] d);
        raddr = a;
        @(negedge clk);
        d = rdata;
    endtask

    task automatic check_buf(input string tag);
        rd_t         e;
        logic [31:0] d;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_word(e.addr, d);
            check(tag, d, e.data);
        end
        tick();
    endtask

    task automatic pulse_rearm();
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
    endtask

    initial begin
        logic [31:0] d;

        tick(3);
        check("rst_tready", {31'b0, tready}, 0);
        check("rst_received", {31'b0, received}, 0);
        check("rst_tlast_err", {31'b0, tlast_err}, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("rel_tready", {31'b0, tready}, 1);

        r0 = recv_cnt;
        send_frame(0, 8, 7, 0, 1);
        check("a_recv_hi", {31'b0, received}, 1);
        tick();
        check("a_recv_lo", {31'b0, received}, 0);
        check("a_tready_lo", {31'b0, tready}, 0);
        tick();
        check("a_recv_cnt", recv_cnt - r0, 1);
        check("a_tlast_err", {31'b0, tlast_err}, 0);
        read_word(0, d);
        check("a_rd0", d, 32'h0);
        read_word(1, d);
        check("a_rd1", d, 32'h100);
        read_word(15, d);
        check("a_rd15", d, 32'h107);
        check_buf("a_buf");

        pulse_rearm();
        check("b_tready", {31'b0, tready}, 1);
        r0 = recv_cnt;
        send_frame('h20, 8, 7, 1, 1);
        tick(2);
        check("b_recv_cnt", recv_cnt - r0, 1);
        check("b_tready_lo", {31'b0, tready}, 0);
        check_buf("b_buf");

        pulse_rearm();
        r0 = recv_cnt;
        send_frame('h40, 4, 3, 0, 0);
        tick(2);
        check("c_err_early", {31'b0, tlast_err}, 1);
        check("c_no_recv", recv_cnt - r0, 0);
        check("c_tready", {31'b0, tready}, 1);
        send_frame('h60, 8, 7, 0, 1);
        tick(2);
        check("c_recv_cnt", recv_cnt - r0, 1);
        check("c_err_sticky", {31'b0, tlast_err}, 1);
        check_buf("c_buf");
        pulse_rearm();
        check("c_err_clear", {31'b0, tlast_err}, 0);

        r0 = recv_cnt;
        send_frame('h80, 8, -1, 0, 1);
        tick(2);
        check("d_recv_cnt", recv_cnt - r0, 1);
        check("d_err_missing", {31'b0, tlast_err}, 1);
        tvalid = 1'b1;
        tdata  = beat('hF0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("d_hold_tready", {31'b0, tready}, 0);
        end
        tvalid = 1'b0;
        check_buf("d_buf");
        pulse_rearm();

        r0 = recv_cnt;
        send_frame('hA0, 7, -1, 0, 0);
        rearm = 1'b1;
        send_beat(beat('hA0, 7), 1'b1, 0, 7);
        rearm = 1'b0;
        check("e_no_recv_now", {31'b0, received}, 0);
        check("e_tready", {31'b0, tready}, 1);
        check("e_err", {31'b0, tlast_err}, 0);
        tick(2);
        check("e_no_recv", recv_cnt - r0, 0);
        send_frame('hC0, 7, -1, 0, 1);
        tick(2);
        check("e_no_early_done", recv_cnt - r0, 0);
        send_beat(beat('hC0, 7), 1'b1, 1, 7);
        tick(2);
        check("e_recv_cnt", recv_cnt - r0, 1);
        check_buf("e_buf");

        pulse_rearm();
        r0 = recv_cnt;
        send_frame('hE0, 5, -1, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("f_async_tready", {31'b0, tready}, 0);
        check("f_received", {31'b0, received}, 0);
        tick(3);
        check("f_no_recv", recv_cnt - r0, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("f_tready", {31'b0, tready}, 1);
        check("f_err", {31'b0, tlast_err}, 0);
        send_frame('h140, 8, 7, 0, 1);
        tick(2);
        check("f_recv_cnt", recv_cnt - r0, 1);
        check_buf("f_buf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
